// File: rtl/ttc3_pkg.sv
// Shared types for the ttc3 secure-boot DUS loader: FSM states, result codes
// and the default secret geometry.
package ttc3_pkg;

  localparam int DEF_DUS_WIDTH  = 256;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DUS_WORDS      = DEF_DUS_WIDTH / DEF_WORD_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CHECK,
    ST_WRITE,
    ST_WAIT_VALID,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ERR_OTP            = 3'd1,
    ERR_TIMEOUT        = 3'd2,
    ERR_CHECKSUM       = 3'd3,
    ERR_ALREADY_LOCKED = 3'd4,
    ERR_NOT_LOCKED     = 3'd5
  } err_e;

endpackage

// File: rtl/ttc3_dus_loader.sv
// Fetches the device unique secret from OTP word by word, verifies the XOR
// checksum word and performs the single write into DUS storage.
module ttc3_dus_loader import ttc3_pkg::*; #(
  parameter int DUS_WIDTH      = DEF_DUS_WIDTH,
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int NW = DUS_WIDTH / WORD_WIDTH,
  localparam int AW = $clog2(NW + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  otp_req,
  output logic [AW-1:0]         otp_addr,
  input  logic                  otp_ack,
  input  logic [WORD_WIDTH-1:0] otp_rdata,
  input  logic                  otp_err,
  input  logic                  dus_valid,
  output logic                  write_enable,
  output logic [DUS_WIDTH-1:0]  write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            error_code
);

  state_e                state_q;
  err_e                  err_q;
  logic                  done_q;
  logic                  error_q;
  logic [AW-1:0]         idx_q;
  logic [TW-1:0]         tmo_q;
  logic [WORD_WIDTH-1:0] acc_q;
  logic [WORD_WIDTH-1:0] chk_q;
  logic [DUS_WIDTH-1:0]  buf_q;

  // Every entry into DONE or ERROR also wipes buf/acc/chk so no secret
  // material outlives the load attempt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      idx_q   <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      chk_q   <= '0;
      buf_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            if (dus_valid) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
              err_q   <= ERR_ALREADY_LOCKED;
              buf_q   <= '0;
              acc_q   <= '0;
              chk_q   <= '0;
            end else begin
              state_q <= ST_REQ;
              error_q <= 1'b0;
              err_q   <= ERR_NONE;
              idx_q   <= '0;
              acc_q   <= '0;
              tmo_q   <= '0;
            end
          end
        end

        ST_REQ: begin
          if (otp_ack) begin
            tmo_q <= '0;
            if (otp_err) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
              err_q   <= ERR_OTP;
              buf_q   <= '0;
              acc_q   <= '0;
              chk_q   <= '0;
            end else if (idx_q == AW'(NW)) begin
              chk_q   <= otp_rdata;
              state_q <= ST_CHECK;
            end else begin
              for (int w = 0; w < NW; w++) begin
                if (idx_q == AW'(w)) buf_q[w*WORD_WIDTH +: WORD_WIDTH] <= otp_rdata;
              end
              acc_q <= acc_q ^ otp_rdata;
              idx_q <= idx_q + AW'(1);
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            err_q   <= ERR_TIMEOUT;
            buf_q   <= '0;
            acc_q   <= '0;
            chk_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        ST_CHECK: begin
          if (acc_q == chk_q) begin
            state_q <= ST_WRITE;
          end else begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            err_q   <= ERR_CHECKSUM;
            buf_q   <= '0;
            acc_q   <= '0;
            chk_q   <= '0;
          end
        end

        ST_WRITE: state_q <= ST_WAIT_VALID;

        ST_WAIT_VALID: begin
          buf_q <= '0;
          acc_q <= '0;
          chk_q <= '0;
          if (dus_valid) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
            err_q   <= ERR_NOT_LOCKED;
          end
        end

        ST_DONE: state_q <= ST_DONE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode the flopped state, so reset removes them asynchronously.
  assign otp_req      = (state_q == ST_REQ);
  assign otp_addr     = idx_q;
  assign write_enable = (state_q == ST_WRITE);
  assign write_data   = write_enable ? buf_q : '0;
  assign busy         = (state_q == ST_REQ) || (state_q == ST_CHECK) ||
                        (state_q == ST_WRITE) || (state_q == ST_WAIT_VALID);
  assign done         = done_q;
  assign error        = error_q;
  assign error_code   = err_q;

endmodule

// File: tb/tb_ttc3_dus_loader.sv
// Directed bench for ttc3_dus_loader with a behavioural OTP responder and a
// DUS storage model that locks on the write strobe.
module tb_ttc3_dus_loader;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         otp_req;
  logic [3:0]   otp_addr;
  logic         otp_ack = 1'b0;
  logic [31:0]  otp_rdata = '0;
  logic         otp_err = 1'b0;
  logic         dus_valid = 1'b0;
  logic         write_enable;
  logic [255:0] write_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [2:0]   error_code;

  int testsRun = 0;
  int testsFailed = 0;

  logic [31:0] mem [0:15];
  logic        ackEnable = 1'b1;
  logic        errEnable = 1'b0;
  logic [3:0]  errWord = '0;
  logic        storageWorks = 1'b1;
  logic        forceLocked = 1'b0;
  logic        locked = 1'b0;

  int           weCycle, weCount, doneCycle, errCycle, lastReqCycle;
  logic         reqC1;
  logic [3:0]   addrC1;
  logic [255:0] weData;
  logic [255:0] expData;

  ttc3_dus_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .otp_req(otp_req), .otp_addr(otp_addr), .otp_ack(otp_ack),
    .otp_rdata(otp_rdata), .otp_err(otp_err), .dus_valid(dus_valid),
    .write_enable(write_enable), .write_data(write_data), .busy(busy),
    .done(done), .error(error), .error_code(error_code)
  );

  always #5 clock = ~clock;

  // OTP and storage models update mid-cycle so the DUT sees stable inputs.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) locked = 1'b0;
    else if (write_enable && storageWorks) locked = 1'b1;
    dus_valid = forceLocked | locked;
    otp_ack   = otp_req && ackEnable;
    otp_rdata = otp_ack ? mem[otp_addr] : 32'h0;
    otp_err   = otp_ack && errEnable && (otp_addr == errWord);
  end

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    start   = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Pulses start in cycle 0, optionally again at two later cycles, and
  // records what the loader did over a fixed number of cycles.
  task automatic applyStimulus(input int maxCyc, input int again1, input int again2);
    weCycle = -1; weCount = 0; doneCycle = -1; errCycle = -1; lastReqCycle = -1;
    weData = '0; reqC1 = 1'b0; addrC1 = 4'hf;
    start = 1'b1;
    for (int c = 1; c <= maxCyc; c++) begin
      @(negedge clock);
      start = (c == again1) || (c == again2);
      if (c == 1) begin reqC1 = otp_req; addrC1 = otp_addr; end
      if (otp_req) lastReqCycle = c;
      if (write_enable) begin
        weCount++;
        if (weCycle < 0) begin weCycle = c; weData = write_data; end
      end
      if (done && doneCycle < 0) doneCycle = c;
      if (error && errCycle < 0) errCycle = c;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    mem[8] = 32'h8;
    for (int w = 0; w < 8; w++) expData[w*32 +: 32] = mem[w];

    repeat (2) @(negedge clock);
    checkOutput("reset_outputs",
                256'({otp_req, busy, write_enable, done, error, error_code, otp_addr}), 256'(0));
    checkOutput("reset_wdata", write_data, 256'(0));
    reset_n = 1'b1;

    // Nominal load, with ignored starts while busy and after done.
    applyStimulus(30, 5, 20);
    checkOutput("nom_req_c1", 256'(reqC1), 256'(1));
    checkOutput("nom_addr_c1", 256'(addrC1), 256'(0));
    checkOutput("nom_we_cycle", 256'(weCycle), 256'(11));
    checkOutput("nom_wdata_lo", 256'(weData[31:0]), 256'(32'h1));
    checkOutput("nom_wdata_hi", 256'(weData[255:224]), 256'(32'h8));
    checkOutput("nom_wdata_all", weData, expData);
    checkOutput("nom_done_cycle", 256'(doneCycle), 256'(13));
    checkOutput("nom_error", 256'(error), 256'(0));
    checkOutput("nom_we_count", 256'(weCount), 256'(1));
    checkOutput("nom_last_req", 256'(lastReqCycle), 256'(9));
    checkOutput("nom_busy_end", 256'(busy), 256'(0));
    checkOutput("nom_wdata_idle", write_data, 256'(0));

    // Bad checksum.
    mem[8] = 32'h9;
    doReset();
    applyStimulus(20, 0, 0);
    checkOutput("csum_err_cycle", 256'(errCycle), 256'(11));
    checkOutput("csum_code", 256'(error_code), 256'(3));
    checkOutput("csum_we_count", 256'(weCount), 256'(0));
    checkOutput("csum_buf_zero", dut.buf_q, 256'(0));
    mem[8] = 32'h8;

    // OTP fault on word 3.
    errEnable = 1'b1; errWord = 4'd3;
    doReset();
    applyStimulus(20, 0, 0);
    checkOutput("otp_err_cycle", 256'(errCycle), 256'(5));
    checkOutput("otp_code", 256'(error_code), 256'(1));
    checkOutput("otp_last_req", 256'(lastReqCycle), 256'(4));
    checkOutput("otp_buf_zero", dut.buf_q, 256'(0));
    errEnable = 1'b0;

    // Timeout on word 0, then a good load from the ERROR state.
    ackEnable = 1'b0;
    doReset();
    applyStimulus(70, 0, 0);
    checkOutput("tmo_err_cycle", 256'(errCycle), 256'(65));
    checkOutput("tmo_last_req", 256'(lastReqCycle), 256'(64));
    checkOutput("tmo_code", 256'(error_code), 256'(2));
    ackEnable = 1'b1;
    applyStimulus(20, 0, 0);
    checkOutput("retry_done_cycle", 256'(doneCycle), 256'(13));
    checkOutput("retry_error", 256'(error), 256'(0));
    checkOutput("retry_code", 256'(error_code), 256'(0));
    checkOutput("retry_we_count", 256'(weCount), 256'(1));

    // Storage already locked.
    forceLocked = 1'b1;
    doReset();
    applyStimulus(10, 0, 0);
    checkOutput("locked_err_cycle", 256'(errCycle), 256'(1));
    checkOutput("locked_code", 256'(error_code), 256'(4));
    checkOutput("locked_no_req", 256'(lastReqCycle), 256'(-1));
    forceLocked = 1'b0;

    // Storage never locks.
    storageWorks = 1'b0;
    doReset();
    applyStimulus(20, 0, 0);
    checkOutput("nolock_we_cycle", 256'(weCycle), 256'(11));
    checkOutput("nolock_err_cycle", 256'(errCycle), 256'(13));
    checkOutput("nolock_code", 256'(error_code), 256'(5));
    checkOutput("nolock_done", 256'(done), 256'(0));
    storageWorks = 1'b1;

    // Reset asserted while word 5 is being requested.
    doReset();
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    checkOutput("rst_mid_addr", 256'(otp_addr), 256'(5));
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_outputs",
                256'({otp_req, busy, write_enable, done, error, error_code, otp_addr}), 256'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(20, 0, 0);
    checkOutput("rst_reload_addr", 256'(addrC1), 256'(0));
    checkOutput("rst_reload_done", 256'(doneCycle), 256'(13));
    checkOutput("rst_reload_data", weData, expData);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
